// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one single-consumer cache among NUM_CONSUMERS requesters.
// Optional: define CACHE_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority (no rr pointer).
module cache_arbiter #(
   parameter int NUM_CONSUMERS = 4,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic                               cache_read_valid,
   output logic [ADDR_BITS-1:0]               cache_read_address,
   input  logic                               cache_read_ready,
   input  logic [DATA_BITS-1:0]               cache_read_data,
   output logic                               cache_write_valid,
   output logic [ADDR_BITS-1:0]               cache_write_address,
   output logic [DATA_BITS-1:0]               cache_write_data,
   input  logic                               cache_write_ready,
   input  logic                               cache_idle
);

   localparam int ID_BITS = $clog2(NUM_CONSUMERS);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t                           r_state;
   state_t                           w_state_next;
   logic [ID_BITS-1:0]               r_id;
   logic                             r_is_write;
   logic                             r_cache_read_valid;
   logic                             r_cache_write_valid;
   logic [ADDR_BITS-1:0]             r_cache_read_address;
   logic [ADDR_BITS-1:0]             r_cache_write_address;
   logic [DATA_BITS-1:0]             r_cache_write_data;
   logic [NUM_CONSUMERS-1:0]         r_consumer_read_ready;
   logic [NUM_CONSUMERS-1:0]         r_consumer_write_ready;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] r_consumer_read_data;

   logic [NUM_CONSUMERS-1:0]         w_pending;
   logic                             w_found;
   logic [ID_BITS-1:0]               w_winner;
   logic                             w_grant;
   logic                             w_done;
   logic [ADDR_BITS-1:0]             w_rd_addr [NUM_CONSUMERS];
   logic [ADDR_BITS-1:0]             w_wr_addr [NUM_CONSUMERS];
   logic [DATA_BITS-1:0]             w_wr_data [NUM_CONSUMERS];

   for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_unpack
      assign w_rd_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
      assign w_wr_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
      assign w_wr_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
   end

   assign w_pending = consumer_read_valid | consumer_write_valid;

`ifdef CACHE_ARB_FIXED_PRIORITY_EN
   // Descending scan so the lowest pending index is the last (winning) assignment.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
         if (w_pending[i]) begin
            w_found  = 1'b1;
            w_winner = ID_BITS'(i);
         end
      end
   end
`else
   logic [ID_BITS-1:0] r_rr_ptr;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      int v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
         v_idx = int'(r_rr_ptr) + i;
         if (v_idx >= NUM_CONSUMERS) v_idx = v_idx - NUM_CONSUMERS;
         if (!w_found && w_pending[ID_BITS'(v_idx)]) begin
            w_found  = 1'b1;
            w_winner = ID_BITS'(v_idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= '0;
      end else if (w_done) begin
         r_rr_ptr <= (r_id == ID_BITS'(NUM_CONSUMERS - 1)) ? '0 : r_id + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A busy cache (fill tail) blocks new grants so its held address stays put.
            if (cache_idle && w_found) begin
               w_grant      = 1'b1;
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (r_is_write ? cache_write_ready : cache_read_ready) begin
               w_done       = 1'b1;
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (cache_idle) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the ready pulses default low each cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_id                   <= '0;
         r_is_write             <= 1'b0;
         r_cache_read_valid     <= 1'b0;
         r_cache_write_valid    <= 1'b0;
         r_cache_read_address   <= '0;
         r_cache_write_address  <= '0;
         r_cache_write_data     <= '0;
         r_consumer_read_ready  <= '0;
         r_consumer_write_ready <= '0;
         r_consumer_read_data   <= '0;
      end else begin
         r_consumer_read_ready  <= '0;
         r_consumer_write_ready <= '0;
         if (w_grant) begin
            r_id       <= w_winner;
            r_is_write <= consumer_write_valid[w_winner];
            // A requester with both ops pending gets its write first; the read waits.
            if (consumer_write_valid[w_winner]) begin
               r_cache_write_valid   <= 1'b1;
               r_cache_write_address <= w_wr_addr[w_winner];
               r_cache_write_data    <= w_wr_data[w_winner];
            end else begin
               r_cache_read_valid    <= 1'b1;
               r_cache_read_address  <= w_rd_addr[w_winner];
            end
         end
         if (w_done) begin
            r_cache_read_valid  <= 1'b0;
            r_cache_write_valid <= 1'b0;
            if (r_is_write) begin
               r_consumer_write_ready[r_id] <= 1'b1;
            end else begin
               r_consumer_read_ready[r_id] <= 1'b1;
               for (int i = 0; i < NUM_CONSUMERS; i++) begin
                  if (r_id == ID_BITS'(i)) r_consumer_read_data[i*DATA_BITS +: DATA_BITS] <= cache_read_data;
               end
            end
         end
      end
   end

   assign cache_read_valid     = r_cache_read_valid;
   assign cache_read_address   = r_cache_read_address;
   assign cache_write_valid    = r_cache_write_valid;
   assign cache_write_address  = r_cache_write_address;
   assign cache_write_data     = r_cache_write_data;
   assign consumer_read_ready  = r_consumer_read_ready;
   assign consumer_write_ready = r_consumer_write_ready;
   assign consumer_read_data   = r_consumer_read_data;

endmodule
